// File: rtl/tpu_seq_if.sv
// Stream and memory-bus signals between the tpu_seq sequencer and its neighbours.
// master = sequencer side, slave = host stream / tpuv1 bus side.
interface tpu_seq_if #(
  parameter int DATAW = 64,
  parameter int ADDRW = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [DATAW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DATAW-1:0] out_data;
  logic             tpu_r_w;
  logic [ADDRW-1:0] tpu_addr;
  logic [DATAW-1:0] tpu_wdata;
  logic [DATAW-1:0] tpu_rdata;

  modport master (
    input  in_valid, in_data, out_ready, tpu_rdata,
    output in_ready, out_valid, out_data, tpu_r_w, tpu_addr, tpu_wdata
  );

  modport slave (
    output in_valid, in_data, out_ready, tpu_rdata,
    input  in_ready, out_valid, out_data, tpu_r_w, tpu_addr, tpu_wdata
  );
endinterface

// File: rtl/tpu_seq.sv
// Host-side sequencer for tpuv1: streams C/A/B words onto the bus, triggers MatMul,
// waits out the array latency, then reads C back as 16 words on the output stream.
//
// state   | meaning
// IDLE    | waiting for start
// LOAD_C  | accepting 2*DIM accumulator preload words
// LOAD_A  | accepting DIM rows of A
// LOAD_B  | accepting DIM rows of B
// TRIGGER | issue the MatMul write
// WAIT    | array latency down-count
// RD_ADDR | present C read address k
// RD_CAP  | capture tpu_rdata into out_data
// RD_OUT  | hold output word until accepted
module tpu_seq #(
  parameter int DIM         = 8,
  parameter int DATAW       = 64,
  parameter int ADDRW       = 16,
  parameter int WAIT_CYCLES = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic acc,
  output logic busy,
  output logic done,
  tpu_seq_if.master bus
);

  localparam int KW = $clog2(2*DIM);
  localparam int WW = $clog2(WAIT_CYCLES+1);

  localparam logic [KW-1:0]    K_LAST_C  = KW'(2*DIM-1);
  localparam logic [KW-1:0]    K_LAST_AB = KW'(DIM-1);
  localparam logic [WW-1:0]    WAIT_LOAD = WW'(WAIT_CYCLES-1);
  localparam logic [ADDRW-1:0] BASE_A    = ADDRW'(16'h0100);
  localparam logic [ADDRW-1:0] BASE_B    = ADDRW'(16'h0200);
  localparam logic [ADDRW-1:0] BASE_C    = ADDRW'(16'h0300);
  localparam logic [ADDRW-1:0] ADDR_TRIG = ADDRW'(16'h0400);

  typedef enum logic [3:0] {
    IDLE, LOAD_C, LOAD_A, LOAD_B, TRIGGER, WAIT, RD_ADDR, RD_CAP, RD_OUT
  } state_t;

  state_t           state;
  logic [KW-1:0]    k;
  logic [WW-1:0]    wait_cnt;
  logic             in_xfer;
  logic [ADDRW-1:0] k_off;

  assign in_xfer = bus.in_valid && bus.in_ready;
  assign k_off   = ADDRW'({k, 3'b000});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      k             <= '0;
      wait_cnt      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= {DATAW{1'b0}};
      bus.tpu_r_w   <= 1'b0;
      bus.tpu_addr  <= '0;
      bus.tpu_wdata <= {DATAW{1'b0}};
    end else begin
      done        <= 1'b0;
      bus.tpu_r_w <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k            <= '0;
            busy         <= 1'b1;
            bus.in_ready <= 1'b1;
            state        <= acc ? LOAD_C : LOAD_A;
          end
        end
        LOAD_C: begin
          if (in_xfer) begin
            bus.tpu_r_w   <= 1'b1;
            bus.tpu_wdata <= bus.in_data;
            bus.tpu_addr  <= BASE_C + k_off;
            if (k == K_LAST_C) begin
              k     <= '0;
              state <= LOAD_A;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        LOAD_A: begin
          if (in_xfer) begin
            bus.tpu_r_w   <= 1'b1;
            bus.tpu_wdata <= bus.in_data;
            bus.tpu_addr  <= BASE_A + k_off;
            if (k == K_LAST_AB) begin
              k     <= '0;
              state <= LOAD_B;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (in_xfer) begin
            bus.tpu_r_w   <= 1'b1;
            bus.tpu_wdata <= bus.in_data;
            bus.tpu_addr  <= BASE_B + k_off;
            if (k == K_LAST_AB) begin
              k            <= '0;
              bus.in_ready <= 1'b0;
              state        <= TRIGGER;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        TRIGGER: begin
          // Outputs are registered, so the trigger write lands in the first WAIT cycle.
          bus.tpu_r_w   <= 1'b1;
          bus.tpu_addr  <= ADDR_TRIG;
          bus.tpu_wdata <= {DATAW{1'b0}};
          wait_cnt      <= WAIT_LOAD;
          state         <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            k     <= '0;
            state <= RD_ADDR;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RD_ADDR: begin
          bus.tpu_addr <= BASE_C + k_off;
          state        <= RD_CAP;
        end
        RD_CAP: begin
          bus.out_data  <= bus.tpu_rdata;
          bus.out_valid <= 1'b1;
          state         <= RD_OUT;
        end
        RD_OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (k == K_LAST_C) begin
              k     <= '0;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              k     <= k + 1'b1;
              state <= RD_ADDR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
